// File: rtl/rv32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rv32_mem_arbiter
// Purpose  : Shares one memory bus port between instruction fetch (IF) and
//            load/store (MEM). Grants one requester at a time, alternating on
//            ties, registers the bus request and the completion, and aborts
//            bus cycles that exceed TIMEOUT_CYCLES with an error completion.
// Revision : 1.0 - initial release
// ============================================================================
module rv32_mem_arbiter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   // instruction fetch requester
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,
   output logic [31:0] if_rdata_o,
   output logic        if_err_o,
   // load/store requester
   input  logic        mem_req_i,
   input  logic        mem_we_i,
   input  logic [3:0]  mem_be_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_wdata_i,
   output logic        mem_gnt_o,
   output logic        mem_rvalid_o,
   output logic [31:0] mem_rdata_o,
   output logic        mem_err_o,
   // shared bus
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i
);

   // Counter is never narrower than 8 bits so small timeouts keep headroom.
   localparam int c_cnt_w = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam bit c_tmo_en = (TIMEOUT_CYCLES != 0);
   localparam logic [c_cnt_w-1:0] c_cnt_last =
      (TIMEOUT_CYCLES == 0) ? '0 : c_cnt_w'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_BUSY_IF  = 2'd1,
      ST_BUSY_MEM = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_last_was_mem;
   logic [c_cnt_w-1:0]   r_cnt;

   logic                 r_bus_req;
   logic                 r_bus_we;
   logic [3:0]           r_bus_be;
   logic [31:0]          r_bus_addr;
   logic [31:0]          r_bus_wdata;

   logic                 r_if_rvalid;
   logic [31:0]          r_if_rdata;
   logic                 r_if_err;
   logic                 r_mem_rvalid;
   logic [31:0]          r_mem_rdata;
   logic                 r_mem_err;

   logic                 w_grant_if;
   logic                 w_grant_mem;
   logic                 w_done;
   logic                 w_tmo;
   logic                 w_cnt_hit;

   assign w_cnt_hit = c_tmo_en && (r_cnt == c_cnt_last);

   // Next-state, grant selection and completion decode.
   always_comb begin
      w_state_nxt = r_state;
      w_grant_if  = 1'b0;
      w_grant_mem = 1'b0;
      w_done      = 1'b0;
      w_tmo       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Grants are suppressed while reset is asserted.
            if (rst_n) begin
               if (mem_req_i && (!if_req_i || !r_last_was_mem)) begin
                  w_grant_mem = 1'b1;
                  w_state_nxt = ST_BUSY_MEM;
               end else if (if_req_i) begin
                  w_grant_if  = 1'b1;
                  w_state_nxt = ST_BUSY_IF;
               end
            end
         end
         ST_BUSY_IF, ST_BUSY_MEM: begin
            // An ack in the same cycle as the timeout wins.
            if (bus_ack_i) begin
               w_done      = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (w_cnt_hit) begin
               w_tmo       = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Bus request registers, timeout counter, tie-break flag and completions.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last_was_mem <= 1'b0;
         r_cnt          <= '0;
         r_bus_req      <= 1'b0;
         r_bus_we       <= 1'b0;
         r_bus_be       <= 4'h0;
         r_bus_addr     <= 32'h0;
         r_bus_wdata    <= 32'h0;
         r_if_rvalid    <= 1'b0;
         r_if_rdata     <= 32'h0;
         r_if_err       <= 1'b0;
         r_mem_rvalid   <= 1'b0;
         r_mem_rdata    <= 32'h0;
         r_mem_err      <= 1'b0;
      end else begin
         r_if_rvalid  <= 1'b0;
         r_mem_rvalid <= 1'b0;
         if (w_grant_if || w_grant_mem) begin
            r_last_was_mem <= w_grant_mem;
            r_cnt          <= '0;
            r_bus_req      <= 1'b1;
            r_bus_we       <= w_grant_mem ? mem_we_i    : 1'b0;
            r_bus_be       <= w_grant_mem ? mem_be_i    : 4'hF;
            r_bus_addr     <= w_grant_mem ? mem_addr_i  : if_addr_i;
            r_bus_wdata    <= w_grant_mem ? mem_wdata_i : 32'h0;
         end else if (w_done || w_tmo) begin
            r_bus_req <= 1'b0;
            if (r_state == ST_BUSY_IF) begin
               r_if_rvalid <= 1'b1;
               r_if_rdata  <= w_done ? bus_rdata_i : 32'h0;
               r_if_err    <= w_tmo;
            end else begin
               r_mem_rvalid <= 1'b1;
               r_mem_rdata  <= (w_done && !r_bus_we) ? bus_rdata_i : 32'h0;
               r_mem_err    <= w_tmo;
            end
         end else if (r_bus_req && c_tmo_en) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
         end
      end
   end

   assign if_gnt_o     = w_grant_if;
   assign mem_gnt_o    = w_grant_mem;
   assign if_rvalid_o  = r_if_rvalid;
   assign if_rdata_o   = r_if_rdata;
   assign if_err_o     = r_if_err;
   assign mem_rvalid_o = r_mem_rvalid;
   assign mem_rdata_o  = r_mem_rdata;
   assign mem_err_o    = r_mem_err;
   assign bus_req_o    = r_bus_req;
   assign bus_we_o     = r_bus_we;
   assign bus_be_o     = r_bus_be;
   assign bus_addr_o   = r_bus_addr;
   assign bus_wdata_o  = r_bus_wdata;

endmodule
`default_nettype wire

// File: tb/tb_rv32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32_mem_arbiter
// Purpose  : Self-checking bench for rv32_mem_arbiter (TIMEOUT_CYCLES = 4).
//            Table-driven single transactions, arbitration and back-to-back
//            streams, and a reset dropped in the middle of a bus cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32_mem_arbiter;

   localparam int c_tmo = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req_i = 1'b0;
   logic [31:0] if_addr_i = 32'h0;
   logic        if_gnt_o, if_rvalid_o, if_err_o;
   logic [31:0] if_rdata_o;
   logic        mem_req_i = 1'b0;
   logic        mem_we_i = 1'b0;
   logic [3:0]  mem_be_i = 4'h0;
   logic [31:0] mem_addr_i = 32'h0;
   logic [31:0] mem_wdata_i = 32'h0;
   logic        mem_gnt_o, mem_rvalid_o, mem_err_o;
   logic [31:0] mem_rdata_o;
   logic        bus_req_o, bus_we_o;
   logic [3:0]  bus_be_o;
   logic [31:0] bus_addr_o, bus_wdata_o;
   logic        bus_ack_i = 1'b0;
   logic [31:0] bus_rdata_i = 32'h0;

   rv32_mem_arbiter #(.TIMEOUT_CYCLES(c_tmo)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
      .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_be_i(mem_be_i),
      .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_gnt_o(mem_gnt_o),
      .mem_rvalid_o(mem_rvalid_o), .mem_rdata_o(mem_rdata_o), .mem_err_o(mem_err_o),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
      .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
      .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t q_if[$];
   exp_t q_mem[$];

   typedef struct {
      logic        is_mem;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] bus_data;
      int          ack_wait;   // 0 = never ack
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_busy;
   } vec_t;
   vec_t vecs[7];

   int          ack_wait  = 1;
   logic [31:0] resp_data = 32'h0;
   int          busy_cnt  = 0;
   logic [31:0] last_if   = 32'h0;
   logic [31:0] last_mem  = 32'h0;

   logic [139:0] all_out;
   assign all_out = {bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o,
                     if_rvalid_o, if_rdata_o, if_err_o,
                     mem_rvalid_o, mem_rdata_o, mem_err_o, if_gnt_o, mem_gnt_o};

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Bus slave: acks in the ack_wait-th busy cycle.
   always @(posedge clk) begin
      #1;
      if (bus_req_o) begin
         busy_cnt  = busy_cnt + 1;
         bus_ack_i = (ack_wait != 0) && (busy_cnt == ack_wait);
      end else begin
         busy_cnt  = 0;
         bus_ack_i = 1'b0;
      end
      bus_rdata_i = resp_data;
   end

   // Scoreboard: every completion must match the oldest expectation queued.
   always @(negedge clk) begin
      exp_t e;
      if (if_gnt_o || mem_gnt_o) check("gnt_exclusive", {if_gnt_o, mem_gnt_o} == 2'b11, 1'b0);
      if (if_rvalid_o || mem_rvalid_o)
         check("rvalid_exclusive", {if_rvalid_o, mem_rvalid_o} == 2'b11, 1'b0);
      if (if_rvalid_o) begin
         if (q_if.size() == 0) check("if_unexpected_rvalid", 1'b1, q_if.size());
         else begin
            e = q_if.pop_front();
            check("if_rdata", if_rdata_o, e.rdata);
            check("if_err", if_err_o, e.err);
         end
      end
      if (mem_rvalid_o) begin
         if (q_mem.size() == 0) check("mem_unexpected_rvalid", 1'b1, q_mem.size());
         else begin
            e = q_mem.pop_front();
            check("mem_rdata", mem_rdata_o, e.rdata);
            check("mem_err", mem_err_o, e.err);
         end
      end
   end

   task automatic run_vec(input vec_t v);
      int  busy = 0;
      bit  done = 1'b0;
      logic [3:0]  ebe;
      logic [31:0] ewd;
      ebe = v.is_mem ? v.be : 4'hF;
      ewd = v.is_mem ? v.wdata : 32'h0;
      @(posedge clk); #1;
      ack_wait  = v.ack_wait;
      resp_data = v.bus_data;
      if (v.is_mem) begin
         mem_req_i = 1'b1; mem_we_i = v.we; mem_be_i = v.be;
         mem_addr_i = v.addr; mem_wdata_i = v.wdata;
         q_mem.push_back('{v.exp_rdata, v.exp_err});
      end else begin
         if_req_i = 1'b1; if_addr_i = v.addr;
         q_if.push_back('{v.exp_rdata, v.exp_err});
      end
      @(negedge clk);
      check("gnt", {if_gnt_o, mem_gnt_o}, v.is_mem ? 2'b01 : 2'b10);
      @(posedge clk); #1;
      // Requester is free to change its attributes after the grant.
      if_req_i = 1'b0; mem_req_i = 1'b0;
      if_addr_i = ~v.addr; mem_addr_i = ~v.addr; mem_wdata_i = ~v.wdata;
      mem_be_i = ~v.be; mem_we_i = ~v.we;
      for (int k = 1; k <= 20 && !done; k++) begin
         @(negedge clk);
         if (bus_req_o) begin
            busy++;
            check("bus_attr", {bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o},
                  {v.is_mem & v.we, ebe, v.addr, ewd});
         end
         if (v.is_mem ? mem_rvalid_o : if_rvalid_o) begin
            done = 1'b1;
            check("latency", k, v.exp_busy + 1);
         end
      end
      check("completed", done, 1'b1);
      check("busy_cycles", busy, v.exp_busy);
      check("other_rdata_held", v.is_mem ? if_rdata_o : mem_rdata_o, v.is_mem ? last_if : last_mem);
      if (v.is_mem) last_mem = v.exp_rdata; else last_if = v.exp_rdata;
   endtask

   // Holds requests continuously; pat bit g = 1 when grant g must go to MEM.
   task automatic run_stream(input int n_if, input int n_mem, input logic [7:0] pat, input int n_exp);
      int g = 0, seen_if = 0, seen_mem = 0;
      @(posedge clk); #1;
      ack_wait  = 1;
      resp_data = 32'h0000_0013;
      for (int i = 0; i < n_if; i++)  q_if.push_back('{32'h0000_0013, 1'b0});
      for (int i = 0; i < n_mem; i++) q_mem.push_back('{32'h0000_0013, 1'b0});
      if_req_i = (n_if > 0);  if_addr_i = 32'h200;
      mem_req_i = (n_mem > 0); mem_we_i = 1'b0; mem_be_i = 4'hF;
      mem_addr_i = 32'h1000; mem_wdata_i = 32'h0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         if (if_gnt_o || mem_gnt_o) begin
            if (g < n_exp) begin
               check("grant_order", mem_gnt_o, pat[g]);
               check("grant_cycle", cyc, 2 * g);
               if (g > 0) check("grant_in_rvalid_cycle", if_rvalid_o | mem_rvalid_o, 1'b1);
            end else check("extra_grant", g, n_exp - 1);
            g++;
            if (if_gnt_o) seen_if++;
            if (mem_gnt_o) seen_mem++;
         end
         @(posedge clk); #1;
         if (seen_if >= n_if) if_req_i = 1'b0;
         if (seen_mem >= n_mem) mem_req_i = 1'b0;
      end
      check("grant_count", g, n_exp);
      check("queues_drained", q_if.size() + q_mem.size(), 0);
      if (n_if > 0) last_if = 32'h0000_0013;
      if (n_mem > 0) last_mem = 32'h0000_0013;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1);
   end

   initial begin
      //         is_mem we    be     addr          wdata         bus_data      wait exp_rdata     err  busy
      vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0,        32'h0010_0093, 1, 32'h0010_0093, 1'b0, 1};
      vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h0000_2004, 32'hDEAD_BEEF, 32'h1234_5678, 3, 32'h0,         1'b0, 3};
      vecs[2] = '{1'b1, 1'b0, 4'hF, 32'h0000_1000, 32'h0,        32'hCAFE_F00D, 2, 32'hCAFE_F00D, 1'b0, 2};
      vecs[3] = '{1'b1, 1'b0, 4'hF, 32'h0000_1008, 32'h0,        32'h7777_7777, 0, 32'h0,         1'b1, 4};
      vecs[4] = '{1'b1, 1'b0, 4'hC, 32'h0000_100C, 32'h0,        32'hA5A5_A5A5, 4, 32'hA5A5_A5A5, 1'b0, 4};
      vecs[5] = '{1'b0, 1'b0, 4'h0, 32'h0000_0104, 32'h0,        32'h5555_5555, 0, 32'h0,         1'b1, 4};
      vecs[6] = '{1'b0, 1'b0, 4'h0, 32'h0000_0108, 32'h0,        32'h1111_2222, 4, 32'h1111_2222, 1'b0, 4};

      // Reset with both requests high: no grant, everything at zero.
      rst_n = 1'b0; if_req_i = 1'b1; mem_req_i = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", all_out, 140'h0);
      @(posedge clk); #1;
      rst_n = 1'b1; if_req_i = 1'b0; mem_req_i = 1'b0;

      // First tie after reset goes to MEM, then strict alternation.
      run_stream(2, 2, 8'b0000_0101, 4);

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Reset in the 2nd busy cycle of a load that is never acked.
      @(posedge clk); #1;
      ack_wait = 0; resp_data = 32'h9999_9999;
      mem_req_i = 1'b1; mem_we_i = 1'b0; mem_be_i = 4'hF; mem_addr_i = 32'h3000;
      @(negedge clk);
      check("drop_gnt", mem_gnt_o, 1'b1);
      @(posedge clk); #1;
      mem_req_i = 1'b0;
      @(negedge clk);
      check("drop_busy1", bus_req_o, 1'b1);
      @(posedge clk); #1;
      rst_n = 1'b0; if_req_i = 1'b1;
      @(negedge clk);
      check("gnt_gated_in_reset", {if_gnt_o, mem_gnt_o}, 2'b00);
      @(posedge clk);
      @(negedge clk);
      check("mid_reset_outputs", all_out, 140'h0);
      @(posedge clk); #1;
      rst_n = 1'b1; if_req_i = 1'b0;
      last_if = 32'h0; last_mem = 32'h0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      check("idle_after_drop", bus_req_o, 1'b0);
      run_vec(vecs[2]);

      // Back-to-back fetches: grant every 2 cycles.
      run_stream(4, 0, 8'b0000_0000, 4);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
